// File: rtl/alu_op_sched_if.sv
// Request/response handshake bundle between a requester and alu_op_sched.
interface alu_op_sched_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [3:0] req_a;
   logic [3:0] req_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/alu_op_sched.sv
// ALU result-select sequencer: accepts one op, holds its one-hot select for
// the op's latency, captures the result register and hands it back.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | select held high, latency counter running down
// CAPT  | selects low, result register output valid, captured at the edge
// RESP  | response presented, waiting for rsp_ready
module alu_op_sched #(
   parameter int CMP_LAT = 1,
   parameter int ADD_LAT = 1,
   parameter int SUB_LAT = 1,
   parameter int DIV_LAT = 4,
   parameter int MUL_LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   alu_op_sched_if.slave bus,
   output logic [3:0]   A,
   output logic [3:0]   B,
   output logic         aCmp,
   output logic         aAdd,
   output logic         aSub,
   output logic         aDiv,
   output logic         aMul,
   input  logic [7:0]   res_in,
   output logic [7:0]   ops_cnt,
   output logic         busy
);

   if (CMP_LAT < 1 || CMP_LAT > 15 || ADD_LAT < 1 || ADD_LAT > 15 ||
       SUB_LAT < 1 || SUB_LAT > 15 || DIV_LAT < 1 || DIV_LAT > 15 ||
       MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
      $error("alu_op_sched: latency parameters must lie in 1..15");
   end

   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  a_q, a_d;
   logic [3:0]  b_q, b_d;
   logic [4:0]  sel_q, sel_d;      // bit index equals opcode
   logic [3:0]  cnt_q, cnt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic [7:0]  ops_q, ops_d;

   function automatic logic [3:0] lat_of(input logic [2:0] op);
      case (op)
         3'd0:    lat_of = 4'(CMP_LAT);
         3'd1:    lat_of = 4'(ADD_LAT);
         3'd2:    lat_of = 4'(SUB_LAT);
         3'd3:    lat_of = 4'(DIV_LAT);
         default: lat_of = 4'(MUL_LAT);
      endcase
   endfunction

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      ops_d       = ops_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               a_d = bus.req_a;
               b_d = bus.req_b;
               if (bus.req_op <= 3'd4) begin
                  sel_d   = 5'd1 << bus.req_op;
                  cnt_d   = lat_of(bus.req_op) - 4'd1;
                  state_d = EXEC;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = 8'h00;
                  rsp_err_d   = 1'b1;
                  state_d     = RESP;
               end
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               sel_d   = 5'd0;
               state_d = CAPT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         CAPT: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = res_in;
            rsp_err_d   = 1'b0;
            state_d     = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
               if (!rsp_err_q) begin
                  ops_d = ops_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; async reset also drops the selects immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= 4'd0;
         b_q         <= 4'd0;
         sel_q       <= 5'd0;
         cnt_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_err_q   <= 1'b0;
         ops_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         ops_q       <= ops_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE) && !rst;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign A             = a_q;
   assign B             = b_q;
   assign aCmp          = sel_q[0];
   assign aAdd          = sel_q[1];
   assign aSub          = sel_q[2];
   assign aDiv          = sel_q[3];
   assign aMul          = sel_q[4];
   assign ops_cnt       = ops_q;
   assign busy          = (state_q != IDLE);

   a_sel_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(sel_q));
   a_sel_in_exec: assert property (@(posedge clk) disable iff (rst)
                                   (sel_q != 5'd0) |-> (state_q == EXEC));

endmodule

// File: tb/tb_alu_op_sched.sv
// Self-checking bench for alu_op_sched: vector table, hand sequences for
// reset/back-pressure/wrap, then randomized ops against a reference model.
module tb_alu_op_sched;
   localparam int CMP_LAT = 1;
   localparam int ADD_LAT = 1;
   localparam int SUB_LAT = 1;
   localparam int DIV_LAT = 4;
   localparam int MUL_LAT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] A, B;
   logic       aCmp, aAdd, aSub, aDiv, aMul;
   logic [7:0] res_in;
   logic [7:0] ops_cnt;
   logic       busy;

   alu_op_sched_if bus();

   alu_op_sched #(
      .CMP_LAT(CMP_LAT), .ADD_LAT(ADD_LAT), .SUB_LAT(SUB_LAT),
      .DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .A(A), .B(B),
      .aCmp(aCmp), .aAdd(aAdd), .aSub(aSub), .aDiv(aDiv), .aMul(aMul),
      .res_in(res_in), .ops_cnt(ops_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int overlap_errs = 0;
   int sel_outside = 0;
   int model_ops = 0;

   function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int ia;
      int ib;
      ia = int'(a);
      ib = int'(b);
      case (op)
         3'd0:    return (ia > ib) ? 8'h01 : ((ia == ib) ? 8'h00 : 8'hFF);
         3'd1:    return 8'(ia + ib);
         3'd2:    return 8'(ia - ib);
         3'd3:    return (ib == 0) ? 8'hFF : 8'(ia / ib);
         3'd4:    return 8'(ia * ib);
         default: return 8'h00;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op);
      case (op)
         3'd0:    return CMP_LAT;
         3'd1:    return ADD_LAT;
         3'd2:    return SUB_LAT;
         3'd3:    return DIV_LAT;
         3'd4:    return MUL_LAT;
         default: return 0;
      endcase
   endfunction

   // Result register model: loads f(A,B) while a select is high.
   logic [7:0] y_q;
   always @(posedge clk or posedge rst) begin
      if (rst)       y_q <= 8'h00;
      else if (aCmp) y_q <= ref_result(3'd0, A, B);
      else if (aAdd) y_q <= ref_result(3'd1, A, B);
      else if (aSub) y_q <= ref_result(3'd2, A, B);
      else if (aDiv) y_q <= ref_result(3'd3, A, B);
      else if (aMul) y_q <= ref_result(3'd4, A, B);
   end
   assign res_in = y_q;

   always @(posedge clk) cyc <= cyc + 1;

   // Select sanity monitor over the whole run.
   always @(negedge clk) begin
      if (!rst) begin
         if ($countones({aMul, aDiv, aSub, aAdd, aCmp}) > 1) overlap_errs++;
         if (({aMul, aDiv, aSub, aAdd, aCmp} != 5'd0) && !busy) sel_outside++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request, observe it to the response, optionally back-pressure.
   task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input int hold,
                         output logic [7:0] data, output logic err, output int t_valid,
                         output int sel_n, output int sel_first, output int sel_last,
                         output int wrong_sel, output int hold_bad);
      logic [4:0] s;
      logic [4:0] exp_mask;
      int t;
      exp_mask  = (op <= 3'd4) ? (5'd1 << op) : 5'd0;
      sel_n = 0; sel_first = 0; sel_last = 0; wrong_sel = 0; hold_bad = 0; t_valid = -1;
      data = 8'h00; err = 1'b0;
      if (bus.req_ready !== 1'b1) hold_bad++;
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
      @(posedge clk);
      accept_cyc = cyc;
      #1;
      bus.req_valid = 1'b0;
      t = 1;
      while (t <= 40) begin
         s = {aMul, aDiv, aSub, aAdd, aCmp};
         if ((s & ~exp_mask) != 5'd0) wrong_sel++;
         if ((s & exp_mask) != 5'd0) begin
            sel_n++;
            if (sel_first == 0) sel_first = t;
            sel_last = t;
            if (A !== a || B !== b) hold_bad++;
         end
         if (bus.rsp_valid === 1'b1) begin
            t_valid = t;
            break;
         end
         @(posedge clk); #1;
         t++;
      end
      if (t_valid < 0) begin
         check("rsp_timeout", {31'd0, bus.rsp_valid}, 32'd1);
         return;
      end
      data = bus.rsp_data;
      err  = bus.rsp_err;
      for (int i = 0; i < hold; i++) begin
         bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_a = ~a; bus.req_b = ~b;
         @(posedge clk); #1;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== data || bus.rsp_err !== err ||
             bus.req_ready !== 1'b0) hold_bad++;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic do_vec(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input int hold, input logic [7:0] exp_data, input logic exp_err);
      logic [7:0] data;
      logic err;
      int tv, sn, sf, sl, ws, hb, lat;
      run_op(op, a, b, hold, data, err, tv, sn, sf, sl, ws, hb);
      lat = ref_lat(op);
      check({tag, "_rsp_data"}, 32'(data), 32'(exp_data));
      check({tag, "_rsp_err"}, 32'(err), 32'(exp_err));
      check({tag, "_rsp_cycle"}, tv, exp_err ? 1 : lat + 2);
      check({tag, "_sel_cycles"}, sn, exp_err ? 0 : lat);
      if (lat > 0) check({tag, "_sel_window"}, {sf[15:0], sl[15:0]}, {16'd1, 16'(lat)});
      check({tag, "_wrong_sel"}, ws, 0);
      check({tag, "_hold_stable"}, hb, 0);
      if (!exp_err) model_ops = (model_ops + 1) % 256;
      check({tag, "_ops_cnt"}, 32'(ops_cnt), model_ops);
      check({tag, "_idle_after"}, {30'd0, bus.req_ready, busy}, 32'd2);
      check({tag, "_A_kept"}, {A, B}, {a, b});
   endtask

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      int         hold;
      logic [7:0] data;
      logic       err;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [7:0] data;
      logic err;
      int tv, sn, sf, sl, ws, hb;
      int bad, prev_accept, spacing;
      logic [7:0] pre_wrap, at_wrap;
      logic [2:0] rop;
      logic [3:0] ra, rb;
      int rhold;

      vecs[0]  = '{3'd1, 4'd3,  4'd5,  0, 8'h08, 1'b0};
      vecs[1]  = '{3'd3, 4'd12, 4'd3,  0, 8'h04, 1'b0};
      vecs[2]  = '{3'd4, 4'd7,  4'd6,  5, 8'h2A, 1'b0};
      vecs[3]  = '{3'd6, 4'd9,  4'd2,  0, 8'h00, 1'b1};
      vecs[4]  = '{3'd2, 4'd2,  4'd5,  1, 8'hFD, 1'b0};
      vecs[5]  = '{3'd0, 4'd9,  4'd4,  0, 8'h01, 1'b0};
      vecs[6]  = '{3'd0, 4'd4,  4'd4,  2, 8'h00, 1'b0};
      vecs[7]  = '{3'd3, 4'd5,  4'd0,  0, 8'hFF, 1'b0};
      vecs[8]  = '{3'd4, 4'd15, 4'd15, 0, 8'hE1, 1'b0};
      vecs[9]  = '{3'd7, 4'd1,  4'd1,  3, 8'h00, 1'b1};
      vecs[10] = '{3'd1, 4'd15, 4'd15, 0, 8'h1E, 1'b0};
      vecs[11] = '{3'd0, 4'd2,  4'd9,  0, 8'hFF, 1'b0};

      bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_a = 4'd0; bus.req_b = 4'd0;
      bus.rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_req_ready_rel", {31'd0, bus.req_ready}, 32'd1);
      check("rst_selects", {27'd0, aMul, aDiv, aSub, aAdd, aCmp}, 32'd0);
      check("rst_rsp", {22'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'd0);
      check("rst_ops_ab_busy", {15'd0, busy, ops_cnt, A, B}, 32'd0);

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         do_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hold, vecs[i].data, vecs[i].err);
      end

      // Reset during the second EXEC cycle of a divide
      bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_a = 4'd12; bus.req_b = 4'd3;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check("div_sel_pre_rst", {31'd0, aDiv}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_sel", {27'd0, aMul, aDiv, aSub, aAdd, aCmp}, 32'd0);
      check("mid_rst_rsp", {22'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'd0);
      check("mid_rst_ops_ab_busy", {14'd0, bus.req_ready, busy, ops_cnt, A, B}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_ops = 0;
      @(posedge clk); #1;
      do_vec("post_rst_add", 3'd1, 4'd1, 4'd1, 0, 8'h02, 1'b0);

      // 256 back-to-back compares: ops_cnt wraps
      bad = 0; prev_accept = 0; spacing = 0;
      pre_wrap = 8'hAA; at_wrap = 8'hAA;
      for (int i = 0; i < 256; i++) begin
         ra = 4'($urandom); rb = 4'($urandom);
         run_op(3'd0, ra, rb, 0, data, err, tv, sn, sf, sl, ws, hb);
         if (data !== ref_result(3'd0, ra, rb) || err !== 1'b0 || tv != 3 || sn != 1 ||
             ws != 0 || hb != 0) bad++;
         model_ops = (model_ops + 1) % 256;
         if (ops_cnt !== 8'(model_ops)) bad++;
         if (model_ops == 255) pre_wrap = ops_cnt;
         if (model_ops == 0) at_wrap = ops_cnt;
         if (i == 1) spacing = accept_cyc - prev_accept;
         prev_accept = accept_cyc;
      end
      check("cmp_run_bad", bad, 0);
      check("ops_pre_wrap", 32'(pre_wrap), 32'hFF);
      check("ops_at_wrap", 32'(at_wrap), 32'h00);
      check("accept_spacing", spacing, 4);

      // Randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = 4'($urandom); rb = 4'($urandom);
         rhold = $urandom_range(0, 3);
         do_vec($sformatf("rnd%0d", i), rop, ra, rb, rhold, ref_result(rop, ra, rb), rop > 3'd4);
      end

      check("sel_overlap", overlap_errs, 0);
      check("sel_outside_busy", sel_outside, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
